// File: rtl/ce_seq_gen.sv
// ce_seq_gen: start-qualified c/b pulse generator with 1..MAX_DLY delay.
// Define CE_SEQ_GEN_OVR_EN to build the sticky overrun flag on ovr.
module ce_seq_gen #(
    parameter int MAX_DLY = 5,
    parameter int DLY_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             ce,
    input  logic [DLY_W-1:0] dly,
    output logic             c,
    output logic             b,
    output logic             busy,
    output logic             abort,
    output logic             ovr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CPH,
        BPH
    } state_t;

    localparam logic [DLY_W-1:0] MAX_V = DLY_W'(MAX_DLY);
    localparam logic [DLY_W-1:0] ONE   = DLY_W'(1);

    state_t           state;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] eff;

    always_comb begin
        eff = dly;
        if (dly == '0)
            eff = ONE;
        else if (dly > MAX_V)
            eff = MAX_V;
    end

    // c/b/abort are single-cycle: cleared every edge unless set below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            c     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            abort <= 1'b0;
        end else begin
            c     <= 1'b0;
            b     <= 1'b0;
            abort <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a && ce) begin
                        busy <= 1'b1;
                        if (eff == ONE) begin
                            state <= CPH;
                            c     <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= eff - ONE;
                        end
                    end
                end
                WAIT: begin
                    if (!ce) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end else if (cnt == ONE) begin
                        state <= CPH;
                        c     <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                CPH: begin
                    if (!ce) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end else begin
                        state <= BPH;
                        b     <= 1'b1;
                    end
                end
                BPH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!ce)
                        abort <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CE_SEQ_GEN_OVR_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovr <= 1'b0;
        else if (a && busy)
            ovr <= 1'b1;
    end
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_ce_seq_gen.sv
// Bench for ce_seq_gen: per-edge vector table through a scoreboard queue,
// plus a delay sweep measuring a->c latency with bounded waits.
module tb_ce_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b0;
    logic       ce  = 1'b0;
    logic [2:0] dly = 3'd0;
    logic       c, b, busy, abort, ovr;

    int total = 0;
    int bad   = 0;

`ifdef CE_SEQ_GEN_OVR_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    ce_seq_gen #(.MAX_DLY(5), .DLY_W(3)) dut (
        .clk(clk), .rst(rst), .a(a), .ce(ce), .dly(dly),
        .c(c), .b(b), .busy(busy), .abort(abort), .ovr(ovr)
    );

    always #5 clk = ~clk;

    // exp = {c, b, busy, abort, ovr} just after the row's edge
    typedef struct {
        logic       rst;
        logic       a;
        logic       ce;
        logic [2:0] dly;
        logic [4:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] sb[$];
    int         sb_id[$];
    logic       ovr_m  = 1'b0;
    logic       busy_m = 1'b0;

    task automatic add(input logic r, input logic ai, input logic cei,
                       input logic [2:0] d, input logic ec, input logic eb,
                       input logic ebusy, input logic eab);
        vec_t v;
        if (r)
            ovr_m = 1'b0;
        else if (ai && busy_m)
            ovr_m = 1'b1;
        busy_m = ebusy;
        v.rst = r;
        v.a   = ai;
        v.ce  = cei;
        v.dly = d;
        v.exp = {ec, eb, ebusy, eab, OVR_EN ? ovr_m : 1'b0};
        tbl.push_back(v);
    endtask

    task automatic add_seq(input logic [2:0] dl, input int d);
        add(0, 1, 1, dl, logic'(d == 1), 0, 1, 0);
        for (int i = 1; i < d; i++)
            add(0, 0, 1, dl, logic'(i == d - 1), 0, 1, 0);
        add(0, 0, 1, dl, 0, 1, 1, 0);
        add(0, 0, 1, dl, 0, 0, 0, 0);
    endtask

    task automatic check(input string nm, input logic [4:0] got,
                         input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: c,b,busy,abort,ovr got=%b want=%b",
                     nm, got, exp);
        end
    endtask

    task automatic check_i(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
        end
    endtask

    logic [4:0] e;
    int         id;
    int         n;
    int         expd;

    initial begin
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add_seq(3'd3, 3);
        add_seq(3'd0, 1);
        add_seq(3'd7, 5);
        add_seq(3'd5, 5);
        add_seq(3'd1, 1);
        add_seq(3'd2, 2);
        // ce drop in WAIT
        add(0, 1, 1, 4, 0, 0, 1, 0);
        add(0, 0, 1, 4, 0, 0, 1, 0);
        add(0, 0, 0, 4, 0, 0, 0, 1);
        repeat (7) add(0, 0, 1, 4, 0, 0, 0, 0);
        // ce drop in CPH
        add(0, 1, 1, 2, 0, 0, 1, 0);
        add(0, 0, 1, 2, 1, 0, 1, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1);
        repeat (2) add(0, 0, 1, 0, 0, 0, 0, 0);
        // ce drop in BPH
        add(0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // a without ce
        add(0, 1, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, logic'(i % 3 == 0), 0, 3, 0, 0, 0, 0);
        // reset mid-sequence, then fresh start
        add(0, 1, 1, 5, 0, 0, 1, 0);
        add(0, 0, 1, 5, 0, 0, 1, 0);
        add(1, 0, 1, 5, 0, 0, 0, 0);
        repeat (2) add(0, 0, 1, 0, 0, 0, 0, 0);
        add_seq(3'd2, 2);
        // overrun: a while busy, and a during BPH
        add(0, 1, 1, 5, 0, 0, 1, 0);
        add(0, 0, 1, 5, 0, 0, 1, 0);
        add(0, 1, 1, 5, 0, 0, 1, 0);
        add(0, 0, 1, 5, 0, 0, 1, 0);
        add(0, 0, 1, 5, 1, 0, 1, 0);
        add(0, 0, 1, 5, 0, 1, 1, 0);
        add(0, 1, 1, 5, 0, 0, 0, 0);
        repeat (2) add(0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                id = sb_id.pop_front();
                check($sformatf("row%0d", id), {c, b, busy, abort, ovr}, e);
            end
            rst = tbl[i].rst;
            a   = tbl[i].a;
            ce  = tbl[i].ce;
            dly = tbl[i].dly;
            sb.push_back(tbl[i].exp);
            sb_id.push_back(i);
        end
        @(negedge clk);
        e  = sb.pop_front();
        id = sb_id.pop_front();
        check($sformatf("row%0d", id), {c, b, busy, abort, ovr}, e);

        for (int dl = 0; dl < 8; dl++) begin
            expd = (dl == 0) ? 1 : ((dl > 5) ? 5 : dl);
            a   = 1'b1;
            ce  = 1'b1;
            dly = 3'(dl);
            @(negedge clk);
            a = 1'b0;
            n = 1;
            while (c !== 1'b1 && n < 12) begin
                @(negedge clk);
                n++;
            end
            check_i($sformatf("lat_dly%0d", dl), n, expd);
            @(negedge clk);
            check_i($sformatf("b_dly%0d", dl), int'({c, b, busy}), 3);
            @(negedge clk);
            check_i($sformatf("end_dly%0d", dl), int'({c, b, busy, abort}), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
